// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and op-bit indices for the memory pipeline stage.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 121;
    localparam int unsigned MS_TO_WS_BUS_WD = 70;
    localparam int unsigned BR_BUS_WD       = 33;

    localparam int unsigned LoadOpW   = 5;
    localparam int unsigned BranchOpW = 9;

    // load_op bit positions (one-hot or zero)
    localparam int unsigned OpLdB  = 0;
    localparam int unsigned OpLdH  = 1;
    localparam int unsigned OpLdW  = 2;
    localparam int unsigned OpLdBu = 3;
    localparam int unsigned OpLdHu = 4;

    // branch_op bit positions
    localparam int unsigned BrEq   = 0;
    localparam int unsigned BrNe   = 1;
    localparam int unsigned BrLt   = 2;
    localparam int unsigned BrGe   = 3;
    localparam int unsigned BrLtu  = 4;
    localparam int unsigned BrGeu  = 5;
    localparam int unsigned BrB    = 6;
    localparam int unsigned BrBl   = 7;
    localparam int unsigned BrJirl = 8;

    typedef struct packed {
        logic [31:0]          br_target;
        logic [BranchOpW-1:0] branch_op;
        logic                 carry;
        logic                 sign;
        logic                 overflow;
        logic                 zero;
        logic [LoadOpW-1:0]   load_op;
        logic                 mem_to_reg;
        logic                 reg_we;
        logic [4:0]           dest;
        logic [31:0]          result;
        logic [31:0]          pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// Execute/memory/writeback handshake and bus signals seen by the memory stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [31:0]                data_sram_rdata;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic [31:0]                ms_to_es_bus;

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, br_bus, ms_to_es_bus
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, br_bus, ms_to_es_bus
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]        data_i,
    input  logic [1:0]         addr_i,
    input  logic [LoadOpW-1:0] load_op_i,
    output logic [31:0]        value_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign shifted   = data_i >> {addr_i, 3'b000};
    assign byte_lane = shifted[7:0];
    assign half_lane = addr_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        value_o = '0;
        unique case (1'b1)
            load_op_i[OpLdB]:  value_o = {{24{byte_lane[7]}}, byte_lane};
            load_op_i[OpLdH]:  value_o = {{16{half_lane[15]}}, half_lane};
            load_op_i[OpLdW]:  value_o = data_i;
            load_op_i[OpLdBu]: value_o = {24'h0, byte_lane};
            load_op_i[OpLdHu]: value_o = {16'h0, half_lane};
            default:           value_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: branch resolution, load-data hold/align and writeback handoff.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  ms_io
);

    logic        ms_valid_q, ms_valid_d;
    es_to_ms_t   ins_q, ins_d;
    logic        first_q, first_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic        rdata_buf_valid_q, rdata_buf_valid_d;
    logic        br_done_q, br_done_d;

    logic        ms_ready_go;
    logic        ms_allowin;
    logic        accept;
    logic        leave;
    logic        hold_rdata;
    logic        taken_cond;
    logic        br_taken;
    logic [31:0] load_data;
    logic [31:0] load_value;
    logic [31:0] final_result;
    ms_to_ws_t   ws_out;

    assign ms_ready_go = 1'b1;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ms_io.ws_allowin);
    assign accept      = ms_io.es_to_ms_valid && ms_allowin;
    assign leave       = ms_valid_q && ms_io.ws_allowin;
    // SRAM data is only guaranteed in the first cycle; keep it if we cannot leave then.
    assign hold_rdata  = first_q && ms_valid_q && !ms_io.ws_allowin;

    always_comb begin
        logic lt_signed;
        lt_signed  = ins_q.sign ^ ins_q.overflow;
        taken_cond = (ins_q.branch_op[BrEq]   &  ins_q.zero)
                   | (ins_q.branch_op[BrNe]   & !ins_q.zero)
                   | (ins_q.branch_op[BrLt]   &  lt_signed)
                   | (ins_q.branch_op[BrGe]   & !lt_signed)
                   | (ins_q.branch_op[BrLtu]  &  ins_q.carry)
                   | (ins_q.branch_op[BrGeu]  & !ins_q.carry)
                   |  ins_q.branch_op[BrB]
                   |  ins_q.branch_op[BrBl]
                   |  ins_q.branch_op[BrJirl];
    end

    assign br_taken  = ms_valid_q && taken_cond && !br_done_q;
    assign load_data = rdata_buf_valid_q ? rdata_buf_q : ms_io.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .data_i    (load_data),
        .addr_i    (ins_q.result[1:0]),
        .load_op_i (ins_q.load_op),
        .value_o   (load_value)
    );

    assign final_result = ins_q.mem_to_reg ? load_value : ins_q.result;

    always_comb begin
        ms_valid_d        = ms_allowin ? ms_io.es_to_ms_valid : ms_valid_q;
        ins_d             = accept ? es_to_ms_t'(ms_io.es_to_ms_bus) : ins_q;
        first_d           = accept;
        rdata_buf_d       = hold_rdata ? ms_io.data_sram_rdata : rdata_buf_q;
        rdata_buf_valid_d = rdata_buf_valid_q;
        br_done_d         = br_done_q;
        if (accept || leave) begin
            rdata_buf_valid_d = 1'b0;
            br_done_d         = 1'b0;
        end else begin
            if (hold_rdata) begin
                rdata_buf_valid_d = 1'b1;
            end
            if (br_taken && !ms_io.ws_allowin) begin
                br_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q        <= 1'b0;
            ins_q             <= '0;
            first_q           <= 1'b0;
            rdata_buf_q       <= '0;
            rdata_buf_valid_q <= 1'b0;
            br_done_q         <= 1'b0;
        end else begin
            ms_valid_q        <= ms_valid_d;
            ins_q             <= ins_d;
            first_q           <= first_d;
            rdata_buf_q       <= rdata_buf_d;
            rdata_buf_valid_q <= rdata_buf_valid_d;
            br_done_q         <= br_done_d;
        end
    end

    assign ws_out.reg_we       = ins_q.reg_we;
    assign ws_out.dest         = ins_q.dest;
    assign ws_out.final_result = final_result;
    assign ws_out.pc           = ins_q.pc;

    assign ms_io.ms_allowin     = ms_allowin;
    assign ms_io.ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_io.ms_to_ws_bus   = ws_out;
    assign ms_io.br_bus         = {br_taken, ins_q.br_target};
    assign ms_io.ms_to_es_bus   = ms_valid_q ? final_result : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a per-cycle reference model and literal spot checks.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if ms_if();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .ms_io (ms_if)
    );

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic es_to_ms_t mk(input logic [31:0] tgt, input logic [8:0] bop,
                                     input logic [3:0] csoz, input logic [4:0] lop,
                                     input logic m2r, input logic we, input logic [4:0] dst,
                                     input logic [31:0] res, input logic [31:0] pc);
        es_to_ms_t b;
        b.br_target  = tgt;
        b.branch_op  = bop;
        b.carry      = csoz[3];
        b.sign       = csoz[2];
        b.overflow   = csoz[1];
        b.zero       = csoz[0];
        b.load_op    = lop;
        b.mem_to_reg = m2r;
        b.reg_we     = we;
        b.dest       = dst;
        b.result     = res;
        b.pc         = pc;
        return b;
    endfunction

    // Reference rules written straight from the instruction semantics.
    function automatic logic f_cond(input es_to_ms_t i);
        bit lt_s, lt_u;
        lt_s = (i.sign != i.overflow);
        lt_u = i.carry;
        case (1'b1)
            i.branch_op[0]: return i.zero;
            i.branch_op[1]: return !i.zero;
            i.branch_op[2]: return lt_s;
            i.branch_op[3]: return !lt_s;
            i.branch_op[4]: return lt_u;
            i.branch_op[5]: return !lt_u;
            i.branch_op[6], i.branch_op[7], i.branch_op[8]: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] f_final(input es_to_ms_t i, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        int          a;
        a = int'(i.result[1:0]);
        b = d[8*a +: 8];
        h = d[16*(a/2) +: 16];
        if (!i.mem_to_reg) return i.result;
        case (i.load_op)
            5'b00001: return 32'($signed(b));
            5'b00010: return 32'($signed(h));
            5'b00100: return d;
            5'b01000: return {24'h0, b};
            5'b10000: return {16'h0, h};
            default:  return 32'h0;
        endcase
    endfunction

    // Model state: the instruction in the stage, its age, the load word it saw
    // in its first cycle, and whether it has already redirected fetch.
    es_to_ms_t   m_ins   = '0;
    logic        m_valid = 1'b0;
    int unsigned m_age   = 0;
    logic [31:0] m_ldata = 32'h0;
    logic        m_redir = 1'b0;

    logic [31:0] m_data;
    logic [31:0] m_final;
    logic        m_taken;

    assign m_data  = (m_age == 0) ? ms_if.data_sram_rdata : m_ldata;
    assign m_final = f_final(m_ins, m_data);
    assign m_taken = m_valid && f_cond(m_ins) && !m_redir;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_ins   <= '0;
            m_redir <= 1'b0;
            m_age   <= 0;
        end else begin
            if (m_valid && m_age == 0) m_ldata <= ms_if.data_sram_rdata;
            if (m_taken) m_redir <= 1'b1;
            m_age <= m_age + 1;
            if (!m_valid || ms_if.ws_allowin) begin
                m_valid <= ms_if.es_to_ms_valid;
                if (ms_if.es_to_ms_valid) begin
                    m_ins   <= ms_if.es_to_ms_bus;
                    m_age   <= 0;
                    m_redir <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("allowin", 70'(ms_if.ms_allowin), 70'(!m_valid || ms_if.ws_allowin));
            chk("ws_valid", 70'(ms_if.ms_to_ws_valid), 70'(m_valid));
            chk("br_bus", 70'(ms_if.br_bus), 70'({m_taken, m_ins.br_target}));
            chk("fwd", 70'(ms_if.ms_to_es_bus), 70'(m_valid ? m_final : 32'h0));
            if (m_valid)
                chk("ws_bus", ms_if.ms_to_ws_bus,
                    {m_ins.reg_we, m_ins.dest, m_final, m_ins.pc});
        end
    end

    task automatic issue(input es_to_ms_t b);
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus   = b;
        tick();
        ms_if.es_to_ms_valid = 1'b0;
    endtask

    es_to_ms_t beq;

    initial begin
        ms_if.ws_allowin      = 1'b1;
        ms_if.es_to_ms_valid  = 1'b0;
        ms_if.es_to_ms_bus    = '0;
        ms_if.data_sram_rdata = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
        run   = 1'b1;
        #1;
        chk("rst_valid", 70'(ms_if.ms_to_ws_valid), 70'd0);
        chk("rst_br", 70'(ms_if.br_bus), 70'd0);
        chk("rst_allowin", 70'(ms_if.ms_allowin), 70'd1);

        // ld.b from byte 3
        issue(mk(32'h0, 9'h0, 4'h0, 5'b00001, 1'b1, 1'b1, 5'd4, 32'h1003, 32'h1C000000));
        ms_if.data_sram_rdata = 32'h80FF7F01;
        #1;
        chk("ldb_valid", 70'(ms_if.ms_to_ws_valid), 70'd1);
        chk("ldb_res", 70'(ms_if.ms_to_ws_bus[63:32]), 70'h0FFFFFF80);
        chk("ldb_we", 70'(ms_if.ms_to_ws_bus[69]), 70'd1);
        tick();
        chk("ldb_gone", 70'(ms_if.ms_to_ws_valid), 70'd0);

        // ld.hu upper half, writeback stalled while SRAM data goes away
        ms_if.ws_allowin = 1'b0;
        issue(mk(32'h0, 9'h0, 4'h0, 5'b10000, 1'b1, 1'b1, 5'd6, 32'h2002, 32'h1C000010));
        ms_if.data_sram_rdata = 32'hBEEF1234;
        #1;
        chk("ldhu_c0", 70'(ms_if.ms_to_ws_bus[63:32]), 70'h0000BEEF);
        tick();
        ms_if.data_sram_rdata = 32'h0;
        #1;
        chk("ldhu_c1", 70'(ms_if.ms_to_ws_bus[63:32]), 70'h0000BEEF);
        tick();
        chk("ldhu_c2", 70'(ms_if.ms_to_ws_bus[63:32]), 70'h0000BEEF);
        chk("ldhu_stall", 70'(ms_if.ms_allowin), 70'd0);
        ms_if.ws_allowin = 1'b1;
        #1;
        chk("ldhu_c3", 70'(ms_if.ms_to_ws_bus[63:32]), 70'h0000BEEF);
        tick();
        chk("ldhu_gone", 70'(ms_if.ms_to_ws_valid), 70'd0);

        // beq taken, no stall
        beq = mk(32'h1C000040, 9'h001, 4'b0001, 5'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C000020);
        issue(beq);
        chk("beq_br", 70'(ms_if.br_bus), 70'({1'b1, 32'h1C000040}));
        tick();
        chk("beq_once", 70'(ms_if.br_bus[32]), 70'd0);

        // beq taken while stalled 4 cycles
        ms_if.ws_allowin = 1'b0;
        issue(beq);
        chk("beq_st_c0", 70'(ms_if.br_bus[32]), 70'd1);
        tick();
        chk("beq_st_c1", 70'(ms_if.br_bus[32]), 70'd0);
        tick();
        tick();
        chk("beq_st_c3", 70'(ms_if.br_bus[32]), 70'd0);
        ms_if.ws_allowin = 1'b1;
        tick();

        // bltu with no borrow
        issue(mk(32'h1C000080, 9'h010, 4'b0000, 5'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C000024));
        chk("bltu_nt", 70'(ms_if.br_bus[32]), 70'd0);
        tick();

        // bl: taken, link value goes to writeback
        issue(mk(32'h1C000100, 9'h080, 4'b0000, 5'h0, 1'b0, 1'b1, 5'd1, 32'h1C000034,
                 32'h1C000030));
        chk("bl_taken", 70'(ms_if.br_bus[32]), 70'd1);
        chk("bl_link", 70'(ms_if.ms_to_ws_bus[63:32]), 70'h1C000034);
        tick();

        // back-to-back ALU ops
        ms_if.es_to_ms_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ms_if.es_to_ms_bus = mk(32'h0, 9'h0, 4'h0, 5'h0, 1'b0, 1'b1, 5'(i + 8),
                                    32'h100 * i, 32'h1C000200 + 32'(4 * i));
            #1;
            chk("b2b_allowin", 70'(ms_if.ms_allowin), 70'd1);
            tick();
            #1;
            chk("b2b_pc", 70'(ms_if.ms_to_ws_bus[31:0]), 70'(32'h1C000200 + 32'(4 * i)));
        end
        ms_if.es_to_ms_valid = 1'b0;
        tick();

        // reset in the middle of a stall
        ms_if.ws_allowin = 1'b0;
        issue(beq);
        chk("rs_held", 70'(ms_if.ms_to_ws_valid), 70'd1);
        reset = 1'b1;
        #1;
        chk("rs_valid", 70'(ms_if.ms_to_ws_valid), 70'd0);
        chk("rs_br", 70'(ms_if.br_bus), 70'd0);
        tick();
        reset = 1'b0;
        ms_if.ws_allowin = 1'b1;
        tick();
        tick();
        chk("rs_after", 70'(ms_if.ms_to_ws_valid), 70'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Accepts the execute-to-memory bus and resolves conditional and unconditional branches from the ALU flags, producing a one-shot redirect to fetch.
- Aligns and sign/zero-extends load data returned by data SRAM one cycle after the execute-stage request.
- Forwards its result to execute, and hands {we, dest, result, pc} to writeback under the valid/allowin handshake.

Parameters:
- ES_TO_MS_BUS_WD, 121, width of the incoming bus (from shared header).
- MS_TO_WS_BUS_WD, 70, width of the outgoing bus: {reg_we, dest[4:0], final_result[31:0], pc[31:0]}.
- BR_BUS_WD, 33, width of the redirect bus: {br_taken, br_target[31:0]}.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- ws_allowin  in  1  writeback can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  execute has a valid instruction.
- es_to_ms_bus  in  121  {br_target, branch_op[8:0], Carry, Sign, Overflow, Zero, load_op[4:0], mem_to_reg, reg_we, dest[4:0], result[31:0], pc[31:0]}.
- ms_to_ws_valid  out  1  valid to writeback.
- ms_to_ws_bus  out  70  see parameter.
- data_sram_rdata  in  32  load data, valid the cycle after acceptance.
- br_bus  out  33  redirect to fetch.
- ms_to_es_bus  out  32  forwarded final result.

Behaviour:
- Reset (async) clears ms_valid, rdata_buf_valid and br_done. All outputs are combinational from these registers, so after reset ms_to_ws_valid=0, br_bus=0 and ms_allowin=1.
- Handshake:
  - ms_ready_go=1 always.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - On the clk edge with ms_allowin=1, ms_valid <= es_to_ms_valid.
  - The bus register loads only when es_to_ms_valid && ms_allowin.
- Load data hold: data_sram_rdata is guaranteed only in the first cycle after acceptance.
  - "first" flag is set on acceptance and cleared on the next edge.
  - If first && ms_valid && !ws_allowin, capture rdata into rdata_buf and set rdata_buf_valid.
  - Effective data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
  - rdata_buf_valid clears when the instruction leaves (ms_valid && ws_allowin) or on a new acceptance.
- Load extension: addr = result[1:0].
  - Byte lane = data >> (addr*8); half lane = addr[1] ? data[31:16] : data[15:0].
  - load_op[0] ld.b: sign-extend byte.
  - load_op[1] ld.h: sign-extend half.
  - load_op[2] ld.w: full word.
  - load_op[3] ld.bu: zero-extend byte.
  - load_op[4] ld.hu: zero-extend half.
  - load_op is one-hot or zero.
  - final_result = mem_to_reg ? load value : result.
- Branch resolution:
  - taken_cond = branch_op[0]&Zero | [1]&!Zero | [2]&(Sign^Overflow) | [3]&!(Sign^Overflow) | [4]&Carry | [5]&!Carry | [6] | [7] | [8].
  - Carry=1 denotes unsigned borrow (a<b).
  - br_taken = ms_valid && taken_cond && !br_done.
  - br_target passes through unchanged.
  - br_done sets when br_taken is asserted and ws_allowin=0, so the redirect is one-shot per instruction even while stalled. It clears on instruction departure or acceptance.
- Forwarding: ms_to_es_bus = final_result whenever ms_valid; otherwise 0.
- Simultaneous leave and enter in the same cycle: the new instruction's bus is loaded; rdata_buf_valid, br_done and first are re-initialised for the new instruction.
- Reset asserted mid-stall discards the held instruction and its rdata_buf with no writeback.

Decomposition:
- Shared header (the existing macro include) holds the bus width macros plus load_op and branch_op bit-index constants.
- One natural sub-module: load_align (combinational: data, addr[1:0], load_op -> 32-bit extended value).

Test Plan:
- ld.b, result=0x1003, rdata=0x80FF7F01 -> final_result 0xFFFFFF80, reg_we passed through, one-cycle latency to ms_to_ws_valid.
- ld.hu, addr[1:0]=2, rdata=0xBEEF1234; ws_allowin=0 for 3 cycles while rdata changes to 0 after the first cycle -> result stays 0x0000BEEF until accepted.
- beq with Zero=1, target 0x1C000040 -> br_bus={1,0x1C000040} for exactly one cycle.
- Same beq with ws_allowin low for 4 cycles -> br_bus still asserts exactly one cycle.
- bltu with Carry=0 -> br_taken=0.
- bl -> br_taken=1, and final_result=result (pc+4) reaches writeback.
- Back-to-back ALU ops with ws_allowin=1 -> one instruction per cycle, ms_allowin stays 1.
- Reset asserted mid-stall -> ms_to_ws_valid=0 immediately, br_bus=0, no writeback after reset release.
